// File: rtl/op_tracker.sv
// op_tracker: per-opcode event counters sitting downstream of the capture
// controller. Four saturating-at-LIMIT counters, a running total of accepted
// increments, a saturating round (clear) counter and a sticky protocol-error
// flag. `full` is fed straight back to the controller with zero latency.
//
// Ports:
//   clock    in   rising-edge clock
//   rst_n    in   asynchronous active-low reset
//   en       in   [3:0] one-hot increment request, en[i] -> counter i
//   clear    in   synchronous clear of counters, total and err (beats en)
//   rd_sel   in   [1:0] counter shown on rd_data
//   full     out  any counter equals LIMIT (combinational from registers)
//   rd_data  out  [WIDTH-1:0] selected counter value
//   total    out  [WIDTH+1:0] accepted increments since last clear
//   leader   out  [1:0] argmax of counters, lowest index wins ties
//   rounds   out  [RWIDTH-1:0] clear strobes since reset, saturating
//   err      out  sticky: en had two or more bits high
module op_tracker #(
    parameter int WIDTH  = 8,
    parameter int LIMIT  = 255,
    parameter int RWIDTH = 8
) (
    input  logic              clock,
    input  logic              rst_n,
    input  logic [3:0]        en,
    input  logic              clear,
    input  logic [1:0]        rd_sel,
    output logic              full,
    output logic [WIDTH-1:0]  rd_data,
    output logic [WIDTH+1:0]  total,
    output logic [1:0]        leader,
    output logic [RWIDTH-1:0] rounds,
    output logic              err
);

    localparam logic [WIDTH-1:0] LIM = WIDTH'(LIMIT);

    function automatic logic [2:0] popcount4(input logic [3:0] v);
        return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
    endfunction

    logic [WIDTH-1:0]  cnt_q [4];
    logic [WIDTH-1:0]  cnt_d [4];
    logic [WIDTH+1:0]  total_q, total_d;
    logic [RWIDTH-1:0] rounds_q, rounds_d;
    logic              err_q, err_d;
    logic              full_w;
    logic [3:0]        inc;
    logic [1:0]        lead_w;

    // full is decoded from the registered counts so the controller sees it
    // in the same cycle the limit is reached.
    always_comb begin
        full_w = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (cnt_q[i] == LIM) full_w = 1'b1;
        end
    end

    // Once any counter is full every increment is dropped, which also keeps
    // each counter from ever passing LIMIT.
    always_comb begin
        inc      = en & {4{~full_w & ~clear}};
        total_d  = clear ? '0 : total_q + (WIDTH+2)'(popcount4(inc));
        err_d    = clear ? 1'b0 : (err_q | (popcount4(en) > 3'd1));
        rounds_d = (clear && (rounds_q != '1)) ? rounds_q + 1'b1 : rounds_q;
        for (int i = 0; i < 4; i++) begin
            cnt_d[i] = clear ? '0 : cnt_q[i] + WIDTH'(inc[i]);
        end
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
            total_q  <= '0;
            rounds_q <= '0;
            err_q    <= 1'b0;
        end else begin
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
            total_q  <= total_d;
            rounds_q <= rounds_d;
            err_q    <= err_d;
        end
    end

    // Strictly-greater scan from index 0 so ties keep the lowest index.
    always_comb begin
        lead_w = 2'd0;
        for (int i = 1; i < 4; i++) begin
            if (cnt_q[i] > cnt_q[lead_w]) lead_w = 2'(i);
        end
    end

    assign full    = full_w;
    assign rd_data = cnt_q[rd_sel];
    assign total   = total_q;
    assign leader  = lead_w;
    assign rounds  = rounds_q;
    assign err     = err_q;

endmodule

// File: doc/op_tracker.md
Name: op_tracker

Overview:
Datapath stage directly downstream of the capture controller. It consumes the controller's one-hot increment enables and clear strobe. It keeps four per-opcode event counters, a running total and a round counter, and feeds the `full` flag back to the controller. A read-select port exposes any counter to downstream logic.

Parameters:
WIDTH, 8, bit width of each per-opcode counter.
LIMIT, 255, count value at which `full` asserts. Legal range 1 to 2**WIDTH-1.
RWIDTH, 8, width of the saturating round counter.

Ports:
rst_n  input  1  asynchronous active-low reset
clock  input  1  single clock, all state updates on the rising edge
en  input  4  one-hot increment request; en[i] increments counter i
clear  input  1  synchronous clear of counters, total and err
full  output  1  high when any counter equals LIMIT
rd_sel  input  2  selects the counter shown on rd_data
rd_data  output  WIDTH  value of counter rd_sel (combinational mux of registered counts)
total  output  WIDTH+2  registered sum of accepted increments since last clear
leader  output  2  index of the largest counter; lowest index wins ties
rounds  output  RWIDTH  number of clear strobes since reset, saturating
err  output  1  sticky flag: en not one-hot (two or more bits high)

Behaviour:
- Reset (rst_n low, asynchronous, at any time including mid-round):
  - count0..3 = 0, total = 0, rounds = 0, err = 0.
  - Therefore full = 0, leader = 0, rd_data = 0.
- full:
  - Combinational OR over i of (count_i == LIMIT), decoded from registered counts.
  - Asserts in the same cycle the register holds LIMIT. Zero added latency, so the controller sees it immediately.
- Increment rules, per edge, for each i:
  - If clear: count_i <= 0.
  - Else if en[i] and not full: count_i <= count_i + 1.
  - Else: hold.
  - Counters never exceed LIMIT and never wrap.
  - While full is high, all increments are dropped, including to counters below LIMIT.
- Multiple en bits set (protocol violation):
  - err <= 1. err is sticky until clear or reset.
  - Every enabled counter still increments under the rules above.
  - total adds the popcount of accepted increments.
- total:
  - On clear, total <= 0.
  - Otherwise total <= total + (number of counters incremented this edge).
  - Maximum value is 4*LIMIT, which fits in WIDTH+2 bits, so total cannot overflow.
- clear:
  - Priority over en on the same edge: the increment is lost and the counter goes to 0.
  - full deasserts in the cycle after the clear edge.
- rounds:
  - Increments on every edge where clear = 1 and rounds < 2**RWIDTH-1; holds at maximum.
  - Not reset by clear, only by rst_n.
- leader:
  - Combinational argmax of the four registered counts. Strictly-greater compare, scanning index 0 to 3, so the lowest index wins ties.
  - All zero gives leader = 0.
- rd_data: combinational, reflects the post-edge register value of the selected counter. No pipeline.
- Closed-loop timing with the controller:
  - Edge k: a counter reaches LIMIT; full = 1 during cycle k.
  - Controller enters its clear state at edge k+1; clear = 1 during cycle k+1.
  - Counts zero at edge k+2.
  - The block must tolerate clear held for more than one cycle: it repeatedly zeroes, and rounds counts every cycle that clear is high.
- No X propagation: every output is defined from the first cycle after reset release.

Test Plan:
- Reset/idle (WIDTH=4, LIMIT=5): release rst_n with en=0 for 10 cycles -> all counts 0, total=0, full=0, leader=0, rounds=0, err=0.
- Count to full: pulse en=4'b0100 five times -> count2=5, full=1, total=5, leader=2. A further en=4'b0001 is dropped -> count0 stays 0, total stays 5.
- Clear priority and rounds: with count1=3, apply clear=1 and en=4'b0010 on the same edge -> count1=0, total=0, full=0, rounds=1. Hold clear for 3 cycles -> rounds=4.
- Protocol error: en=4'b0011 for one cycle from zero -> count0=1, count1=1, total=2, err=1. err stays 1 through 10 idle cycles; next clear -> err=0.
- Tie-break and readout: drive count0=2, count3=2, count1=1 -> leader=0. Sweep rd_sel 0..3 -> rd_data = 2,1,0,2.
- Async reset mid-operation: with count2=4 and total=7, drop rst_n between clock edges -> all outputs 0 immediately, before the next edge. After release, en=4'b0100 gives count2=1.
